// File: rtl/i2c_slave_bme280.sv
// i2c_slave_bme280: I2C responder that emulates the BME280 register file.
// SCL/SDA are double-synchronized and edge-detected. SDA is open-drain:
// tristate=1 releases the line, tristate=0 drives sda_out (always 0 then).
// Bus protocol: data is sampled on SCL rise and SDA only changes after SCL
// fall. START/STOP (SDA edge while SCL high) win over bit sampling.
module i2c_slave_bme280 #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h76,
    parameter logic [7:0] CHIP_ID       = 8'h60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        tristate,
    output logic        sda_out,
    input  logic [19:0] press_in,
    input  logic [19:0] temp_in,
    input  logic [15:0] hum_in,
    output logic [7:0]  ctrl_hum,
    output logic [7:0]  ctrl_meas,
    output logic [7:0]  config_out,
    output logic        soft_reset,
    output logic        busy,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d;   // [0] first stage, [1] synced, [2] previous
    logic [2:0]  sda_sync_q, sda_sync_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;         // bits already received in this byte
    logic [6:0]  tx_q, tx_d;               // bits still to send, next one in [6]
    logic [7:0]  ptr_q, ptr_d;
    logic        ack_drv_q, ack_drv_d;     // second phase of an ACK slot
    logic        rw_q, rw_d;
    logic        tristate_q, tristate_d;
    logic        sda_out_q, sda_out_d;
    logic        soft_reset_q, soft_reset_d;
    logic        busy_q, busy_d;
    logic [7:0]  ctrl_hum_q, ctrl_hum_d;
    logic [7:0]  ctrl_meas_q, ctrl_meas_d;
    logic [7:0]  config_q, config_d;
    logic [19:0] press_sh_q, press_sh_d;
    logic [19:0] temp_sh_q, temp_sh_d;
    logic [15:0] hum_sh_q, hum_sh_d;

    logic       scl_s, scl_p, sda_s, sda_p;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;
    logic [7:0] rd_byte;

    assign scl_s     = scl_sync_q[1];
    assign scl_p     = scl_sync_q[2];
    assign sda_s     = sda_sync_q[1];
    assign sda_p     = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
    assign byte_in   = {shift_q, sda_s};

    // Read map, served from the shadow copies so a burst stays coherent
    always_comb begin
        rd_byte = 8'h00;
        case (ptr_q)
            8'hD0:   rd_byte = CHIP_ID;
            8'hF2:   rd_byte = ctrl_hum_q;
            8'hF4:   rd_byte = ctrl_meas_q;
            8'hF5:   rd_byte = config_q;
            8'hF7:   rd_byte = press_sh_q[19:12];
            8'hF8:   rd_byte = press_sh_q[11:4];
            8'hF9:   rd_byte = {press_sh_q[3:0], 4'b0000};
            8'hFA:   rd_byte = temp_sh_q[19:12];
            8'hFB:   rd_byte = temp_sh_q[11:4];
            8'hFC:   rd_byte = {temp_sh_q[3:0], 4'b0000};
            8'hFD:   rd_byte = hum_sh_q[15:8];
            8'hFE:   rd_byte = hum_sh_q[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    // Next-state logic for the protocol FSM, register file and SDA driver
    always_comb begin
        scl_sync_d   = {scl_sync_q[1:0], scl};
        sda_sync_d   = {sda_sync_q[1:0], sda_in};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        ptr_d        = ptr_q;
        ack_drv_d    = ack_drv_q;
        rw_d         = rw_q;
        tristate_d   = tristate_q;
        sda_out_d    = sda_out_q;
        soft_reset_d = 1'b0;
        busy_d       = busy_q;
        ctrl_hum_d   = ctrl_hum_q;
        ctrl_meas_d  = ctrl_meas_q;
        config_d     = config_q;
        press_sh_d   = press_sh_q;
        temp_sh_d    = temp_sh_q;
        hum_sh_d     = hum_sh_q;

        if (start_det) begin
            state_d    = S_ADDR;
            bit_cnt_d  = 4'd0;
            ack_drv_d  = 1'b0;
            tristate_d = 1'b1;
            sda_out_d  = 1'b1;
            busy_d     = 1'b1;
        end else if (stop_det) begin
            state_d    = S_IDLE;
            bit_cnt_d  = 4'd0;
            ack_drv_d  = 1'b0;
            tristate_d = 1'b1;
            sda_out_d  = 1'b1;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            rw_d      = sda_s;
                            ack_drv_d = 1'b0;
                            state_d   = (byte_in[7:1] == SLAVE_ADDRESS) ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            // 8th fall: start the ACK; a read freezes the samples here
                            ack_drv_d  = 1'b1;
                            tristate_d = 1'b0;
                            sda_out_d  = 1'b0;
                            if (rw_q) begin
                                press_sh_d = press_in;
                                temp_sh_d  = temp_in;
                                hum_sh_d   = hum_in;
                            end
                        end else begin
                            ack_drv_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                state_d    = S_RDATA;
                                tx_d       = rd_byte[6:0];
                                tristate_d = rd_byte[7];
                                sda_out_d  = rd_byte[7];
                            end else begin
                                state_d    = S_REG;
                                tristate_d = 1'b1;
                                sda_out_d  = 1'b1;
                            end
                        end
                    end
                end
                S_REG: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            ptr_d     = byte_in;
                            ack_drv_d = 1'b0;
                            state_d   = S_REG_ACK;
                        end
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            ack_drv_d = 1'b0;
                            state_d   = S_WDATA_ACK;
                            ptr_d     = ptr_q + 8'd1;
                            case (ptr_q)
                                8'hF2: ctrl_hum_d  = byte_in;
                                8'hF4: ctrl_meas_d = byte_in;
                                8'hF5: config_d    = byte_in;
                                8'hE0: begin
                                    if (byte_in == 8'hB6) begin
                                        ctrl_hum_d   = 8'h00;
                                        ctrl_meas_d  = 8'h00;
                                        config_d     = 8'h00;
                                        soft_reset_d = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_REG_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            ack_drv_d  = 1'b1;
                            tristate_d = 1'b0;
                            sda_out_d  = 1'b0;
                        end else begin
                            ack_drv_d  = 1'b0;
                            bit_cnt_d  = 4'd0;
                            tristate_d = 1'b1;
                            sda_out_d  = 1'b1;
                            state_d    = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    // bit_cnt counts bits the master has already clocked in
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d  = 4'd0;
                            ack_drv_d  = 1'b0;
                            tristate_d = 1'b1;
                            sda_out_d  = 1'b1;
                            state_d    = S_RDATA_ACK;
                        end else begin
                            tx_d       = {tx_q[5:0], 1'b0};
                            tristate_d = tx_q[6];
                            sda_out_d  = tx_q[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    // ack_drv here marks "master acknowledged, send next byte"
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_q + 8'd1;
                            ack_drv_d = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && ack_drv_q) begin
                        ack_drv_d  = 1'b0;
                        bit_cnt_d  = 4'd0;
                        tx_d       = rd_byte[6:0];
                        tristate_d = rd_byte[7];
                        sda_out_d  = rd_byte[7];
                        state_d    = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset; lines idle high in the synchronizers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            scl_sync_q   <= 3'b111;
            sda_sync_q   <= 3'b111;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 7'd0;
            tx_q         <= 7'd0;
            ptr_q        <= 8'd0;
            ack_drv_q    <= 1'b0;
            rw_q         <= 1'b0;
            tristate_q   <= 1'b1;
            sda_out_q    <= 1'b1;
            soft_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            ctrl_hum_q   <= 8'd0;
            ctrl_meas_q  <= 8'd0;
            config_q     <= 8'd0;
            press_sh_q   <= 20'd0;
            temp_sh_q    <= 20'd0;
            hum_sh_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            ptr_q        <= ptr_d;
            ack_drv_q    <= ack_drv_d;
            rw_q         <= rw_d;
            tristate_q   <= tristate_d;
            sda_out_q    <= sda_out_d;
            soft_reset_q <= soft_reset_d;
            busy_q       <= busy_d;
            ctrl_hum_q   <= ctrl_hum_d;
            ctrl_meas_q  <= ctrl_meas_d;
            config_q     <= config_d;
            press_sh_q   <= press_sh_d;
            temp_sh_q    <= temp_sh_d;
            hum_sh_q     <= hum_sh_d;
        end
    end

    assign tristate   = tristate_q;
    assign sda_out    = sda_out_q;
    assign soft_reset = soft_reset_q;
    assign busy       = busy_q;
    assign ctrl_hum   = ctrl_hum_q;
    assign ctrl_meas  = ctrl_meas_q;
    assign config_out = config_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_i2c_slave_bme280.sv
// tb_i2c_slave_bme280: directed I2C master driving the BME280 responder.
// The bench resolves the open-drain SDA line itself and checks ACKs, read
// bytes (against an expected queue) and the fabric-side register outputs.
module tb_i2c_slave_bme280;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        sda_m;
    logic        sda_line;
    logic        tristate;
    logic        sda_out;
    logic [19:0] press_in;
    logic [19:0] temp_in;
    logic [15:0] hum_in;
    logic [7:0]  ctrl_hum;
    logic [7:0]  ctrl_meas;
    logic [7:0]  config_out;
    logic        soft_reset;
    logic        busy;
    logic [3:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int sr_cnt = 0;
    int drv_cnt = 0;
    logic [7:0] exp_q[$];

    // Wired-AND of master and slave on the SDA net
    assign sda_line = sda_m & (tristate ? 1'b1 : sda_out);

    i2c_slave_bme280 dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda_in     (sda_line),
        .tristate   (tristate),
        .sda_out    (sda_out),
        .press_in   (press_in),
        .temp_in    (temp_in),
        .hum_in     (hum_in),
        .ctrl_hum   (ctrl_hum),
        .ctrl_meas  (ctrl_meas),
        .config_out (config_out),
        .soft_reset (soft_reset),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock and reset-independent monitors
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (soft_reset === 1'b1) sr_cnt++;
        if (tristate === 1'b0) drv_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Quarter SCL period; inputs change 1 ns after the clock edge
    task automatic qp();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qp();
        scl = 1'b1;   qp();
        sda_m = 1'b0; qp();
        scl = 1'b0;   qp();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qp();
        scl = 1'b1;   qp();
        sda_m = 1'b1; qp();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; qp();
        scl = 1'b1; qp(); qp();
        scl = 1'b0; qp();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qp();
        scl = 1'b1;   qp();
        b = sda_line; qp();
        scl = 1'b0;   qp();
    endtask

    task automatic send(input logic [7:0] data, input logic exp_ack, input string tag);
        logic ack;
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        read_bit(ack);
        check(tag, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic recv(input logic ack_bit, input string tag);
        logic [7:0] d;
        logic       b;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
        e = exp_q.pop_front();
        check(tag, {24'd0, d}, {24'd0, e});
    endtask

    task automatic read_id(input string tag);
        i2c_start();
        send(8'hEC, 1'b0, {tag, "_addr_w"});
        send(8'hD0, 1'b0, {tag, "_reg"});
        i2c_start();
        send(8'hED, 1'b0, {tag, "_addr_r"});
        exp_q.push_back(8'h60);
        recv(1'b1, {tag, "_data"});
        i2c_stop();
    endtask

    initial begin
        int sr_base;
        int drv_base;
        logic b;

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
        press_in = '0; temp_in = '0; hum_in = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_tristate", {31'd0, tristate}, 32'd1);
        check("rst_sda_out", {31'd0, sda_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_soft_reset", {31'd0, soft_reset}, 32'd0);
        check("rst_ctrl_hum", {24'd0, ctrl_hum}, 32'h00);
        check("rst_ctrl_meas", {24'd0, ctrl_meas}, 32'h00);
        check("rst_config", {24'd0, config_out}, 32'h00);
        rst = 1'b0;
        qp();

        // Read chip ID with a repeated START
        i2c_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        send(8'hEC, 1'b0, "id_addr_w");
        send(8'hD0, 1'b0, "id_reg");
        i2c_start();
        send(8'hED, 1'b0, "id_addr_r");
        exp_q.push_back(8'h60);
        recv(1'b1, "id_data");
        i2c_stop();
        check("busy_after_stop", {31'd0, busy}, 32'd0);

        // Burst write from F2: F2=01, F3 discarded, F4=27
        i2c_start();
        send(8'hEC, 1'b0, "wr_addr");
        send(8'hF2, 1'b0, "wr_reg");
        send(8'h01, 1'b0, "wr_f2");
        send(8'h00, 1'b0, "wr_f3");
        send(8'h27, 1'b0, "wr_f4");
        i2c_stop();
        check("ctrl_hum_wr", {24'd0, ctrl_hum}, 32'h01);
        check("ctrl_meas_wr", {24'd0, ctrl_meas}, 32'h27);
        check("config_untouched", {24'd0, config_out}, 32'h00);
        i2c_start();
        send(8'hEC, 1'b0, "rb_addr_w");
        send(8'hF4, 1'b0, "rb_reg");
        i2c_start();
        send(8'hED, 1'b0, "rb_addr_r");
        exp_q.push_back(8'h27);
        recv(1'b1, "rb_f4");
        i2c_stop();

        // Burst read of the measurement block; inputs change mid-burst
        press_in = 20'h5A3C1; temp_in = 20'h82F4E; hum_in = 16'h6B2D;
        i2c_start();
        send(8'hEC, 1'b0, "br_addr_w");
        send(8'hF7, 1'b0, "br_reg");
        i2c_start();
        send(8'hED, 1'b0, "br_addr_r");
        exp_q.push_back(8'h5A); exp_q.push_back(8'h3C); exp_q.push_back(8'h10);
        exp_q.push_back(8'h82); exp_q.push_back(8'hF4); exp_q.push_back(8'hE0);
        exp_q.push_back(8'h6B); exp_q.push_back(8'h2D);
        recv(1'b0, "burst0");
        press_in = 20'hFFFFF; temp_in = 20'h12345; hum_in = 16'h0000;
        for (int i = 1; i < 7; i++) recv(1'b0, $sformatf("burst%0d", i));
        recv(1'b1, "burst7");
        i2c_stop();

        // Soft reset: set F4/F5, then E0=B6 clears all control registers
        i2c_start();
        send(8'hEC, 1'b0, "sr_set_addr");
        send(8'hF4, 1'b0, "sr_set_reg");
        send(8'h6C, 1'b0, "sr_set_f4");
        send(8'hA4, 1'b0, "sr_set_f5");
        i2c_stop();
        check("ctrl_meas_set", {24'd0, ctrl_meas}, 32'h6C);
        check("config_set", {24'd0, config_out}, 32'hA4);
        sr_base = sr_cnt;
        i2c_start();
        send(8'hEC, 1'b0, "sr_addr");
        send(8'hE0, 1'b0, "sr_reg");
        send(8'hB6, 1'b0, "sr_data");
        i2c_stop();
        check("soft_reset_pulse_len", sr_cnt - sr_base, 32'd1);
        check("sr_ctrl_hum", {24'd0, ctrl_hum}, 32'h00);
        check("sr_ctrl_meas", {24'd0, ctrl_meas}, 32'h00);
        check("sr_config", {24'd0, config_out}, 32'h00);
        i2c_start();
        send(8'hEC, 1'b0, "sr_rd_addr_w");
        send(8'hF2, 1'b0, "sr_rd_reg");
        i2c_start();
        send(8'hED, 1'b0, "sr_rd_addr_r");
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 3; i++) recv(1'b0, $sformatf("sr_rd_f%0h", 8'hF2 + i));
        recv(1'b1, "sr_rd_f5");
        i2c_stop();
        i2c_start();
        send(8'hEC, 1'b0, "f4_addr");
        send(8'hF4, 1'b0, "f4_reg");
        send(8'h33, 1'b0, "f4_data");
        i2c_stop();
        sr_base = sr_cnt;
        i2c_start();
        send(8'hEC, 1'b0, "e0x_addr");
        send(8'hE0, 1'b0, "e0x_reg");
        send(8'h12, 1'b0, "e0x_data");
        i2c_stop();
        check("no_soft_reset_pulse", sr_cnt - sr_base, 32'd0);
        check("ctrl_meas_kept", {24'd0, ctrl_meas}, 32'h33);

        // Wrong address 0x77: never acknowledged, nothing written
        drv_base = drv_cnt;
        i2c_start();
        send(8'hEE, 1'b1, "wrong_addr_nack");
        send(8'hF4, 1'b1, "wrong_reg_nack");
        send(8'h99, 1'b1, "wrong_data_nack");
        i2c_stop();
        check("wrong_addr_sda_driven", drv_cnt - drv_base, 32'd0);
        check("wrong_addr_ctrl_meas", {24'd0, ctrl_meas}, 32'h33);

        // Reset while the slave drives bit 3 (a 0) of the chip ID
        i2c_start();
        send(8'hEC, 1'b0, "mr_addr_w");
        send(8'hD0, 1'b0, "mr_reg");
        i2c_start();
        send(8'hED, 1'b0, "mr_addr_r");
        for (int i = 0; i < 4; i++) read_bit(b);
        check("mr_driving_bit3", {31'd0, tristate}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mr_released", {31'd0, tristate}, 32'd1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_ctrl_meas", {24'd0, ctrl_meas}, 32'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        qp();
        i2c_stop();
        read_id("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
